// File: rtl/core_pkg.sv
// Shared vector-core types: VRF word/strobe/address, instruction id and the
// writeback request bundle carried from a requester to the VRF write port.
package core_pkg;

  localparam int unsigned VrfDataWidth = 64;
  localparam int unsigned VrfStrbWidth = VrfDataWidth / 8;
  localparam int unsigned VrfAddrWidth = 10;
  localparam int unsigned InsnIdWidth  = 4;

  typedef logic [VrfDataWidth-1:0] vrf_data_t;
  typedef logic [VrfStrbWidth-1:0] vrf_strb_t;
  typedef logic [VrfAddrWidth-1:0] vrf_addr_t;
  typedef logic [InsnIdWidth-1:0]  insn_id_t;

  typedef struct packed {
    vrf_data_t data;
    vrf_strb_t strb;
    vrf_addr_t addr;
    insn_id_t  id;
  } wb_req_t;

endpackage

// File: rtl/rr_arbiter_comb.sv
// Purely combinational round-robin pick: first requester at or after ptr_i,
// wrapping N-1 -> 0. Shared by the VRF read- and write-port arbiters.
module rr_arbiter_comb #(
  parameter int unsigned N = 3
) (
  input  logic [N-1:0]         req_i,
  input  logic [$clog2(N)-1:0] ptr_i,
  output logic [N-1:0]         gnt_o,
  output logic [$clog2(N)-1:0] idx_o,
  output logic                 valid_o
);

  localparam int unsigned IdxW = $clog2(N);

  int j;

  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    j       = 0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr_i) + k;
      if (j >= N) j = j - N;
      if (!valid_o && req_i[j]) begin
        valid_o  = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = IdxW'(j);
      end
    end
  end

endmodule

// File: rtl/vrf_write_arbiter.sv
// Round-robin share of one per-lane VRF write port among NrWbPorts writeback
// units, with a single-entry output register and a commit pulse per retired word.
module vrf_write_arbiter
  import core_pkg::*;
#(
  parameter int unsigned NrWbPorts = 3,
  parameter int unsigned CntWidth  = 8
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [NrWbPorts-1:0]          wb_valid_i,
  input  vrf_data_t                     wb_wdata_i [NrWbPorts],
  input  vrf_strb_t                     wb_wstrb_i [NrWbPorts],
  input  vrf_addr_t                     wb_addr_i  [NrWbPorts],
  input  insn_id_t                      wb_id_i    [NrWbPorts],
  output logic [NrWbPorts-1:0]          wb_gnt_o,
  output logic                          vrf_we_o,
  output vrf_data_t                     vrf_wdata_o,
  output vrf_strb_t                     vrf_wstrb_o,
  output vrf_addr_t                     vrf_waddr_o,
  input  logic                          vrf_ready_i,
  output logic                          commit_valid_o,
  output insn_id_t                      commit_id_o,
  output logic [$clog2(NrWbPorts)-1:0]  commit_port_o,
  output logic [CntWidth-1:0]           gnt_cnt_o  [NrWbPorts]
);

  localparam int unsigned IdxW = $clog2(NrWbPorts);

  logic            we_q, we_d;
  wb_req_t         req_q, req_d;
  logic [IdxW-1:0] port_q, port_d;
  logic [IdxW-1:0] rr_q, rr_d;

  logic                 slot_free;
  logic [NrWbPorts-1:0] arb_req, arb_gnt;
  logic [IdxW-1:0]      arb_idx;
  logic                 arb_valid;

  // The slot may drain and refill in the same cycle, so a ready bank frees it.
  assign slot_free = !we_q || vrf_ready_i;
  assign arb_req   = slot_free ? wb_valid_i : '0;

  rr_arbiter_comb #(
    .N (NrWbPorts)
  ) i_rr_arbiter (
    .req_i   (arb_req),
    .ptr_i   (rr_q),
    .gnt_o   (arb_gnt),
    .idx_o   (arb_idx),
    .valid_o (arb_valid)
  );

  assign wb_gnt_o = arb_gnt;

  always_comb begin
    we_d   = we_q;
    req_d  = req_q;
    port_d = port_q;
    rr_d   = rr_q;
    if (slot_free) we_d = arb_valid;
    if (arb_valid) begin
      req_d  = '{data: wb_wdata_i[arb_idx], strb: wb_wstrb_i[arb_idx],
                 addr: wb_addr_i[arb_idx],  id:   wb_id_i[arb_idx]};
      port_d = arb_idx;
      rr_d   = (arb_idx == IdxW'(NrWbPorts - 1)) ? '0 : arb_idx + IdxW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      we_q <= 1'b0;
      rr_q <= '0;
    end else begin
      we_q <= we_d;
      rr_q <= rr_d;
    end
  end

  // Payload is qualified by we_q, so it needs no reset.
  always_ff @(posedge clk_i) begin
    req_q  <= req_d;
    port_q <= port_d;
  end

  assign vrf_we_o       = we_q;
  assign vrf_wdata_o    = req_q.data;
  assign vrf_wstrb_o    = req_q.strb;
  assign vrf_waddr_o    = req_q.addr;
  assign commit_valid_o = we_q && vrf_ready_i;
  assign commit_id_o    = req_q.id;
  assign commit_port_o  = port_q;

  for (genvar gi = 0; gi < NrWbPorts; gi++) begin : g_cnt
    logic [CntWidth-1:0] cnt_q, cnt_d;

    always_comb begin
      cnt_d = cnt_q;
      if (arb_gnt[gi] && (cnt_q != '1)) cnt_d = cnt_q + CntWidth'(1);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) cnt_q <= '0;
      else         cnt_q <= cnt_d;
    end

    assign gnt_cnt_o[gi] = cnt_q;
  end

  a_gnt_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni)
    $onehot0(wb_gnt_o));

  a_gnt_valid: assert property (@(posedge clk_i) disable iff (!rst_ni)
    ((wb_gnt_o & ~wb_valid_i) == '0));

  a_stall_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (vrf_we_o && !vrf_ready_i) |=>
      $stable({vrf_we_o, vrf_wdata_o, vrf_wstrb_o, vrf_waddr_o, commit_id_o, commit_port_o}));

endmodule

// File: tb/tb_vrf_write_arbiter.sv
// Directed bench for vrf_write_arbiter: one task per scenario, inline checks,
// a second instance with 2-bit counters covers saturation.
module tb_vrf_write_arbiter;
  import core_pkg::*;

  localparam int N = 3;

  logic           clk_i = 1'b0;
  logic           rst_ni;
  logic [N-1:0]   wb_valid;
  vrf_data_t      wb_wdata [N];
  vrf_strb_t      wb_wstrb [N];
  vrf_addr_t      wb_addr  [N];
  insn_id_t       wb_id    [N];
  logic           ready;

  logic [N-1:0]   gnt_a, gnt_b;
  logic           we_a, we_b, cv_a, cv_b;
  vrf_data_t      wdata_a, wdata_b;
  vrf_strb_t      wstrb_a, wstrb_b;
  vrf_addr_t      waddr_a, waddr_b;
  insn_id_t       cid_a, cid_b;
  logic [1:0]     cport_a, cport_b;
  logic [7:0]     cnt_a [N];
  logic [1:0]     cnt_b [N];

  int tests = 0;
  int fails = 0;

  always #5 clk_i = ~clk_i;

  vrf_write_arbiter #(.NrWbPorts(N), .CntWidth(8)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .wb_valid_i(wb_valid), .wb_wdata_i(wb_wdata), .wb_wstrb_i(wb_wstrb),
    .wb_addr_i(wb_addr), .wb_id_i(wb_id), .wb_gnt_o(gnt_a),
    .vrf_we_o(we_a), .vrf_wdata_o(wdata_a), .vrf_wstrb_o(wstrb_a), .vrf_waddr_o(waddr_a),
    .vrf_ready_i(ready), .commit_valid_o(cv_a), .commit_id_o(cid_a),
    .commit_port_o(cport_a), .gnt_cnt_o(cnt_a)
  );

  vrf_write_arbiter #(.NrWbPorts(N), .CntWidth(2)) dut_sat (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .wb_valid_i(wb_valid), .wb_wdata_i(wb_wdata), .wb_wstrb_i(wb_wstrb),
    .wb_addr_i(wb_addr), .wb_id_i(wb_id), .wb_gnt_o(gnt_b),
    .vrf_we_o(we_b), .vrf_wdata_o(wdata_b), .vrf_wstrb_o(wstrb_b), .vrf_waddr_o(waddr_b),
    .vrf_ready_i(ready), .commit_valid_o(cv_b), .commit_id_o(cid_b),
    .commit_port_o(cport_b), .gnt_cnt_o(cnt_b)
  );

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    wb_valid = '0;
    ready    = 1'b1;
    rst_ni   = 1'b0;
    tick();
    tick();
    rst_ni = 1'b1;
  endtask

  task automatic test_reset();
    for (int p = 0; p < N; p++) begin
      wb_wdata[p] = '0; wb_wstrb[p] = '0; wb_addr[p] = '0; wb_id[p] = '0;
    end
    do_reset();
    @(negedge clk_i);
    tests++;
    if ({we_a, cv_a, gnt_a, we_b, cv_b, gnt_b} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: we=%b cv=%b gnt=%b (sat we=%b cv=%b gnt=%b) required all 0",
               we_a, cv_a, gnt_a, we_b, cv_b, gnt_b);
    end
    for (int p = 0; p < N; p++) begin
      tests++;
      if (cnt_a[p] !== 8'd0 || cnt_b[p] !== 2'd0) begin
        fails++;
        $display("FAIL reset_cnt[%0d]: cnt=%0d sat_cnt=%0d required 0", p, cnt_a[p], cnt_b[p]);
      end
    end
    tick();
    $display("[TB] test_reset done");
  endtask

  task automatic test_single_port();
    int commits = 0;
    for (int k = 0; k <= 4; k++) begin
      if (k < 4) begin
        wb_valid    = 3'b001;
        wb_addr[0]  = vrf_addr_t'(10'h10 + k);
        wb_wdata[0] = 64'hA000 + 64'(k);
        wb_wstrb[0] = 8'hF0 | 8'(k);
        wb_id[0]    = insn_id_t'(k);
      end else begin
        wb_valid = '0;
      end
      @(negedge clk_i);
      tests++;
      if (gnt_a !== ((k < 4) ? 3'b001 : 3'b000)) begin
        fails++;
        $display("FAIL single_gnt[%0d]: gnt=%b required %b", k, gnt_a, (k < 4) ? 3'b001 : 3'b000);
      end
      tests++;
      if (k == 0) begin
        if ({we_a, cv_a} !== 2'b00) begin
          fails++;
          $display("FAIL single_latency: we=%b cv=%b required 0 0", we_a, cv_a);
        end
      end else if ({we_a, cv_a, cport_a, cid_a, waddr_a, wdata_a, wstrb_a} !==
                   {1'b1, 1'b1, 2'd0, insn_id_t'(k-1), vrf_addr_t'(10'h10 + k - 1),
                    64'hA000 + 64'(k-1), 8'hF0 | 8'(k-1)}) begin
        fails++;
        $display("FAIL single_commit[%0d]: we=%b cv=%b port=%0d id=%0d addr=%h data=%h strb=%h required 1 1 0 %0d %h %h %h",
                 k, we_a, cv_a, cport_a, cid_a, waddr_a, wdata_a, wstrb_a,
                 k-1, 10'h10 + k - 1, 64'hA000 + 64'(k-1), 8'hF0 | 8'(k-1));
      end
      if (cv_a) begin
        commits++;
        $display("[TB] single commit addr=%h id=%0d port=%0d", waddr_a, cid_a, cport_a);
      end
      tick();
    end
    @(negedge clk_i);
    tests++;
    if ({we_a, cv_a} !== 2'b00 || commits != 4) begin
      fails++;
      $display("FAIL single_drain: we=%b cv=%b commits=%0d required 0 0 4", we_a, cv_a, commits);
    end
    tick();
  endtask

  task automatic test_fairness();
    do_reset();
    for (int p = 0; p < N; p++) begin
      wb_addr[p]  = vrf_addr_t'(10'h100 + p);
      wb_wdata[p] = 64'hD00000 + 64'(p);
      wb_wstrb[p] = 8'h01 << p;
      wb_id[p]    = insn_id_t'(p + 8);
    end
    wb_valid = 3'b111;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk_i);
      tests++;
      if (gnt_a !== (3'b001 << (k % 3))) begin
        fails++;
        $display("FAIL fair_gnt[%0d]: gnt=%b required %b", k, gnt_a, 3'b001 << (k % 3));
      end
      if (k > 0) begin
        tests++;
        if ({cv_a, cport_a, waddr_a, wstrb_a, cid_a} !==
            {1'b1, 2'((k-1) % 3), vrf_addr_t'(10'h100 + (k-1) % 3), 8'h01 << ((k-1) % 3),
             insn_id_t'((k-1) % 3 + 8)}) begin
          fails++;
          $display("FAIL fair_commit[%0d]: cv=%b port=%0d addr=%h strb=%h id=%0d required port %0d",
                   k, cv_a, cport_a, waddr_a, wstrb_a, cid_a, (k-1) % 3);
        end
      end
      tick();
    end
    wb_valid = '0;
    @(negedge clk_i);
    for (int p = 0; p < N; p++) begin
      tests++;
      if (cnt_a[p] !== 8'd10) begin
        fails++;
        $display("FAIL fair_cnt[%0d]: cnt=%0d required 10", p, cnt_a[p]);
      end
    end
    $display("[TB] fairness cnt=%0d,%0d,%0d", cnt_a[0], cnt_a[1], cnt_a[2]);
    tick();
  endtask

  task automatic test_backpressure();
    // pointer is 0 after the 30-grant run
    wb_valid    = 3'b010;
    wb_addr[1]  = vrf_addr_t'(10'h20);
    wb_wdata[1] = 64'hBEEF_0020;
    wb_id[1]    = insn_id_t'(5);
    @(negedge clk_i);
    tests++;
    if (gnt_a !== 3'b010) begin
      fails++;
      $display("FAIL bp_first_gnt: gnt=%b required 010", gnt_a);
    end
    tick();
    wb_addr[1]  = vrf_addr_t'(10'h21);
    wb_wdata[1] = 64'hBEEF_0021;
    wb_id[1]    = insn_id_t'(6);
    ready       = 1'b0;
    for (int s = 0; s < 3; s++) begin
      @(negedge clk_i);
      tests++;
      if ({gnt_a, we_a, cv_a, waddr_a, wdata_a, cid_a, cport_a} !==
          {3'b000, 1'b1, 1'b0, vrf_addr_t'(10'h20), 64'hBEEF_0020, insn_id_t'(5), 2'd1}) begin
        fails++;
        $display("FAIL bp_stall[%0d]: gnt=%b we=%b cv=%b addr=%h data=%h id=%0d port=%0d required 000 1 0 020 beef0020 5 1",
                 s, gnt_a, we_a, cv_a, waddr_a, wdata_a, cid_a, cport_a);
      end
      tick();
    end
    ready = 1'b1;
    @(negedge clk_i);
    tests++;
    if ({gnt_a, cv_a, waddr_a, cid_a} !== {3'b010, 1'b1, vrf_addr_t'(10'h20), insn_id_t'(5)}) begin
      fails++;
      $display("FAIL bp_release: gnt=%b cv=%b addr=%h id=%0d required 010 1 020 5", gnt_a, cv_a, waddr_a, cid_a);
    end
    tick();
    wb_valid = '0;
    @(negedge clk_i);
    tests++;
    if ({cv_a, waddr_a, cid_a} !== {1'b1, vrf_addr_t'(10'h21), insn_id_t'(6)}) begin
      fails++;
      $display("FAIL bp_next_word: cv=%b addr=%h id=%0d required 1 021 6", cv_a, waddr_a, cid_a);
    end
    tick();
    $display("[TB] test_backpressure done");
  endtask

  task automatic test_wrap();
    // pointer is 2 after the last grant to port 1
    wb_valid   = 3'b011;
    wb_addr[0] = vrf_addr_t'(10'h30);
    wb_addr[1] = vrf_addr_t'(10'h31);
    @(negedge clk_i);
    tests++;
    if (gnt_a !== 3'b001) begin
      fails++;
      $display("FAIL wrap_gnt0: gnt=%b required 001", gnt_a);
    end
    tick();
    wb_addr[0] = vrf_addr_t'(10'h32);
    @(negedge clk_i);
    tests++;
    if ({gnt_a, cport_a, waddr_a} !== {3'b010, 2'd0, vrf_addr_t'(10'h30)}) begin
      fails++;
      $display("FAIL wrap_gnt1: gnt=%b port=%0d addr=%h required 010 0 030", gnt_a, cport_a, waddr_a);
    end
    tick();
    wb_valid = '0;
    tick();
    $display("[TB] test_wrap done");
  endtask

  task automatic test_reset_midop();
    wb_valid = 3'b001;
    tick();
    wb_valid = '0;
    #1;
    tests++;
    if (we_a !== 1'b1) begin
      fails++;
      $display("FAIL midop_pre: we=%b required 1", we_a);
    end
    rst_ni = 1'b0;
    #1;
    tests++;
    if ({we_a, cv_a, we_b, cv_b} !== 4'b0000) begin
      fails++;
      $display("FAIL midop_reset: we=%b cv=%b sat we=%b cv=%b required 0", we_a, cv_a, we_b, cv_b);
    end
    tick();
    rst_ni   = 1'b1;
    wb_valid = 3'b111;
    @(negedge clk_i);
    tests++;
    if ({gnt_a, we_a, cv_a} !== {3'b001, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL midop_ptr: gnt=%b we=%b cv=%b required 001 0 0", gnt_a, we_a, cv_a);
    end
    tick();
    wb_valid = '0;
    tick();
    $display("[TB] test_reset_midop done");
  endtask

  task automatic test_saturation();
    do_reset();
    wb_valid = 3'b010;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk_i);
      tests++;
      if (gnt_b !== 3'b010) begin
        fails++;
        $display("FAIL sat_gnt[%0d]: gnt=%b required 010", k, gnt_b);
      end
      tick();
    end
    wb_valid = '0;
    @(negedge clk_i);
    tests++;
    if ({cnt_b[1], cnt_a[1], cnt_b[0], cnt_a[0]} !== {2'd3, 8'd5, 2'd0, 8'd0}) begin
      fails++;
      $display("FAIL sat_cnt: sat_cnt1=%0d cnt1=%0d sat_cnt0=%0d cnt0=%0d required 3 5 0 0",
               cnt_b[1], cnt_a[1], cnt_b[0], cnt_a[0]);
    end
    tick();
    $display("[TB] test_saturation done");
  endtask

  initial begin
    rst_ni   = 1'b0;
    wb_valid = '0;
    ready    = 1'b1;
    test_reset();
    test_single_port();
    test_fairness();
    test_backpressure();
    test_wrap();
    test_reset_midop();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
